// File: rtl/tile_pkg.sv
// Shared types and constants for the tile renderer: write-target select, pixel colour
// and colour-table entry layout.
package tile_pkg;

    typedef enum logic [1:0] {
        SEL_NAME  = 2'd0,
        SEL_PAT   = 2'd1,
        SEL_COLOR = 2'd2,
        SEL_NONE  = 2'd3
    } wr_sel_e;

    localparam int LATENCY = 3;

    typedef logic [23:0] rgb_t;

    typedef struct packed {
        rgb_t fg;
        rgb_t bg;
    } color_entry_t;

endpackage

// File: rtl/tile_sdp_ram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// A read and a write to the same address in one cycle return the old contents.
module tile_sdp_ram
    import tile_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 256,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/tile_renderer.sv
// Character-mode background renderer: name -> pattern -> colour fetch, 3-clk pipeline,
// blank-deferred table writes. Optional scrolling is enabled by defining TILE_SCROLL_EN.
module tile_renderer
    import tile_pkg::*;
#(
    parameter int   COLS_LOG2 = 5,
    parameter int   ROWS      = 24,
    parameter int   TILE_LOG2 = 3,
    parameter int   GRP_LOG2  = 3,
    parameter rgb_t BORDER    = 24'h000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [9:0]  hcount,
    input  logic [9:0]  vcount,
    input  logic        active,
`ifdef TILE_SCROLL_EN
    input  logic [9:0]  scroll_x,
    input  logic [9:0]  scroll_y,
`endif
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [1:0]  wr_sel,
    input  logic [15:0] wr_addr,
    input  logic [47:0] wr_data,
    output logic [23:0] pix_color,
    output logic        pix_valid
);

    localparam int NCOLS      = 1 << COLS_LOG2;
    localparam int TILE       = 1 << TILE_LOG2;
    localparam int NAME_DEPTH = NCOLS * ROWS;
    localparam int PAT_DEPTH  = 256 * TILE;
    localparam int COL_DEPTH  = 256 >> GRP_LOG2;
    localparam int NAME_AW    = $clog2(NAME_DEPTH);
    localparam int PAT_AW     = 8 + TILE_LOG2;
    localparam int COL_AW     = 8 - GRP_LOG2;

    // ---------------- write buffer ----------------
    logic         r_pend;
    wr_sel_e      r_pend_sel;
    logic [15:0]  r_pend_addr;
    logic [47:0]  r_pend_data;
    logic         w_commit;
    logic         w_we_name, w_we_pat, w_we_col;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_pend      <= 1'b0;
            r_pend_sel  <= SEL_NONE;
            r_pend_addr <= '0;
            r_pend_data <= '0;
        end else if (r_pend) begin
            if (!active) begin
                r_pend <= 1'b0;
            end
        end else if (wr_valid) begin
            r_pend      <= 1'b1;
            r_pend_sel  <= wr_sel_e'(wr_sel);
            r_pend_addr <= wr_addr;
            r_pend_data <= wr_data;
        end
    end

    assign wr_ready  = !r_pend;
    assign w_commit  = r_pend && !active;
    // Out-of-range indices are dropped here rather than aliased onto valid entries
    assign w_we_name = w_commit && (r_pend_sel == SEL_NAME)  && (int'(r_pend_addr) < NAME_DEPTH);
    assign w_we_pat  = w_commit && (r_pend_sel == SEL_PAT)   && (int'(r_pend_addr) < PAT_DEPTH);
    assign w_we_col  = w_commit && (r_pend_sel == SEL_COLOR) && (int'(r_pend_addr) < COL_DEPTH);

    // ---------------- S1 coordinate mapping ----------------
    logic [9:0] w_px, w_py;
    logic       w_in_field;

    assign w_in_field = (int'(hcount[9:TILE_LOG2]) < NCOLS) && (int'(vcount[9:TILE_LOG2]) < ROWS);

`ifdef TILE_SCROLL_EN
    localparam int FIELD_W = NCOLS * TILE;
    localparam int FIELD_H = ROWS * TILE;

    logic [9:0]  r_sx, r_sy;
    logic        r_frame_pt_q;
    logic        w_frame_pt;
    logic [10:0] w_ysum;

    assign w_frame_pt = (int'(vcount) == FIELD_H) && !active;

    // sy is stored already reduced so the per-pixel wrap needs only one subtract
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sx         <= '0;
            r_sy         <= '0;
            r_frame_pt_q <= 1'b0;
        end else begin
            r_frame_pt_q <= w_frame_pt;
            if (w_frame_pt && !r_frame_pt_q) begin
                r_sx <= scroll_x;
                r_sy <= 10'(int'(scroll_y) % FIELD_H);
            end
        end
    end

    assign w_ysum = 11'(vcount) + 11'(r_sy);
    assign w_px   = (hcount + r_sx) & 10'(FIELD_W - 1);
    assign w_py   = (int'(w_ysum) >= FIELD_H) ? 10'(int'(w_ysum) - FIELD_H) : w_ysum[9:0];
`else
    assign w_px = hcount;
    assign w_py = vcount;
`endif

    logic [9-TILE_LOG2:0] w_col, w_row;
    logic [NAME_AW-1:0]   w_name_raddr;

    assign w_col        = w_px[9:TILE_LOG2];
    assign w_row        = w_py[9:TILE_LOG2];
    assign w_name_raddr = w_in_field ? NAME_AW'(int'(w_row) * NCOLS + int'(w_col)) : '0;

    // ---------------- tables ----------------
    logic [7:0]         w_name_q;
    logic [TILE-1:0]    w_pat_q;
    color_entry_t       w_color_q;
    logic [TILE_LOG2-1:0] r1_x, r1_y, r2_x;
    logic               r1_in_field, r1_active, r2_in_field, r2_active;

    tile_sdp_ram #(.WIDTH(8), .DEPTH(NAME_DEPTH)) u_name_ram (
        .clk     (clk),
        .i_we    (w_we_name),
        .i_waddr (r_pend_addr[NAME_AW-1:0]),
        .i_wdata (r_pend_data[7:0]),
        .i_raddr (w_name_raddr),
        .o_rdata (w_name_q)
    );

    tile_sdp_ram #(.WIDTH(TILE), .DEPTH(PAT_DEPTH)) u_pat_ram (
        .clk     (clk),
        .i_we    (w_we_pat),
        .i_waddr (r_pend_addr[PAT_AW-1:0]),
        .i_wdata (r_pend_data[TILE-1:0]),
        .i_raddr ({w_name_q, r1_y}),
        .o_rdata (w_pat_q)
    );

    tile_sdp_ram #(.WIDTH(48), .DEPTH(COL_DEPTH)) u_col_ram (
        .clk     (clk),
        .i_we    (w_we_col),
        .i_waddr (r_pend_addr[COL_AW-1:0]),
        .i_wdata (r_pend_data),
        .i_raddr (w_name_q[7:GRP_LOG2]),
        .o_rdata (w_color_q)
    );

    // ---------------- pipeline ----------------
    rgb_t r_pix_color;
    logic r_pix_valid;
    logic w_bit;

    // MSB of a pattern row is the leftmost pixel, so index TILE-1-x == ~x
    assign w_bit = w_pat_q[~r2_x];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1_x        <= '0;
            r1_y        <= '0;
            r1_in_field <= 1'b0;
            r1_active   <= 1'b0;
            r2_x        <= '0;
            r2_in_field <= 1'b0;
            r2_active   <= 1'b0;
            r_pix_color <= '0;
            r_pix_valid <= 1'b0;
        end else begin
            r1_x        <= w_px[TILE_LOG2-1:0];
            r1_y        <= w_py[TILE_LOG2-1:0];
            r1_in_field <= w_in_field;
            r1_active   <= active;
            r2_x        <= r1_x;
            r2_in_field <= r1_in_field;
            r2_active   <= r1_active;
            r_pix_valid <= r2_active;
            if (!r2_active) begin
                r_pix_color <= '0;
            end else if (!r2_in_field) begin
                r_pix_color <= BORDER;
            end else begin
                r_pix_color <= w_bit ? w_color_q.fg : w_color_q.bg;
            end
        end
    end

    assign pix_color = r_pix_color;
    assign pix_valid = r_pix_valid;

endmodule

// File: tb/tb_tile_renderer.sv
// Directed bench for tile_renderer: pixel fetch, border, blank-deferred writes,
// discarded writes and asynchronous reset; scroll check when TILE_SCROLL_EN is defined.
module tb_tile_renderer;

    localparam logic [23:0] TB_BORDER = 24'h005AA5;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [9:0]  hcount, vcount;
    logic        active;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_sel;
    logic [15:0] wr_addr;
    logic [47:0] wr_data;
    logic [23:0] pix_color;
    logic        pix_valid;
`ifdef TILE_SCROLL_EN
    logic [9:0]  scroll_x = '0;
    logic [9:0]  scroll_y = '0;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    tile_renderer #(.BORDER(TB_BORDER)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .hcount    (hcount),
        .vcount    (vcount),
        .active    (active),
`ifdef TILE_SCROLL_EN
        .scroll_x  (scroll_x),
        .scroll_y  (scroll_y),
`endif
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_sel    (wr_sel),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .pix_color (pix_color),
        .pix_valid (pix_valid)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("check %-14s observed %0h expected %0h", tag, obs, exp);
    endtask

    // Assumes blanking and an empty buffer: accept on the first edge, commit on the next
    task automatic do_write(input logic [1:0] sel, input logic [15:0] addr, input logic [47:0] data);
        wr_sel   = sel;
        wr_addr  = addr;
        wr_data  = data;
        wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        tick();
    endtask

    // Hold one pixel position long enough for it to reach the output
    task automatic show(input logic [9:0] h, input logic [9:0] v, input logic act);
        hcount = h;
        vcount = v;
        active = act;
        ticks(3);
    endtask

    initial begin
        reset_n  = 1'b0;
        hcount   = '0;
        vcount   = '0;
        active   = 1'b0;
        wr_valid = 1'b0;
        wr_sel   = '0;
        wr_addr  = '0;
        wr_data  = '0;
        ticks(3);
        check("rst_color", 48'(pix_color), 48'h0);
        check("rst_valid", 48'(pix_valid), 48'h0);
        check("rst_ready", 48'(wr_ready), 48'h1);
        reset_n = 1'b1;
        tick();

        // Table setup during blanking
        do_write(2'd0, 16'd0, 48'h04);
        for (int i = 32; i < 40; i++) do_write(2'd1, 16'(i), 48'hAA);
        do_write(2'd2, 16'd0, {24'h0000FF, 24'hFFFF00});

        // Streamed scan of pixels 0..7 on row 0: output lags input by 3 clocks
        vcount = 10'd0;
        active = 1'b1;
        for (int i = 0; i < 10; i++) begin
            hcount = 10'(i);
            tick();
            if (i >= 2) begin
                check($sformatf("scan_px%0d", i - 2), 48'(pix_color),
                      ((i - 2) % 2 == 0) ? 48'h0000FF : 48'hFFFF00);
                check($sformatf("scan_vld%0d", i - 2), 48'(pix_valid), 48'h1);
            end
        end

        // Border columns/rows and blanking
        show(10'd256, 10'd0, 1'b1);
        check("border_col", 48'(pix_color), 48'(TB_BORDER));
        check("border_vld", 48'(pix_valid), 48'h1);
        show(10'd0, 10'd192, 1'b1);
        check("border_row", 48'(pix_color), 48'(TB_BORDER));
        show(10'd256, 10'd0, 1'b0);
        check("blank_color", 48'(pix_color), 48'h0);
        check("blank_valid", 48'(pix_valid), 48'h0);

        // Writes during active display are held until blanking
        show(10'd0, 10'd0, 1'b1);
        check("act_ready0", 48'(wr_ready), 48'h1);
        wr_sel = 2'd1; wr_addr = 16'd32; wr_data = 48'h0F; wr_valid = 1'b1;
        tick();
        check("act_ready1", 48'(wr_ready), 48'h0);
        wr_sel = 2'd2; wr_addr = 16'd0; wr_data = {24'h00FF00, 24'h000080};
        ticks(4);
        check("act_stall", 48'(wr_ready), 48'h0);
        check("act_olddata", 48'(pix_color), 48'h0000FF);
        active = 1'b0;
        tick();
        check("commit_ready", 48'(wr_ready), 48'h1);
        tick();
        wr_valid = 1'b0;
        check("second_acc", 48'(wr_ready), 48'h0);
        tick();
        check("second_done", 48'(wr_ready), 48'h1);
        show(10'd0, 10'd0, 1'b1);
        check("new_x0", 48'(pix_color), 48'h000080);
        show(10'd4, 10'd0, 1'b1);
        check("new_x4", 48'(pix_color), 48'h00FF00);

        // Discarded writes: sel 3 and out-of-range name indices
        active = 1'b0;
        tick();
        do_write(2'd3, 16'd0, 48'h0C);
        do_write(2'd0, 16'd768, 48'h0C);
        do_write(2'd0, 16'd1024, 48'h0C);
        check("discard_rdy", 48'(wr_ready), 48'h1);
        show(10'd0, 10'd0, 1'b1);
        check("discard_x0", 48'(pix_color), 48'h000080);

        // Asynchronous reset with a write pending
        wr_sel = 2'd2; wr_addr = 16'd0; wr_data = {24'h111111, 24'h222222}; wr_valid = 1'b1;
        tick();
        wr_valid = 1'b0;
        check("pre_rst_rdy", 48'(wr_ready), 48'h0);
        #2 reset_n = 1'b0;
        #1;
        check("arst_color", 48'(pix_color), 48'h0);
        check("arst_valid", 48'(pix_valid), 48'h0);
        check("arst_ready", 48'(wr_ready), 48'h1);
        ticks(2);
        reset_n = 1'b1;
        active  = 1'b0;
        ticks(3);
        show(10'd0, 10'd0, 1'b1);
        check("lost_write", 48'(pix_color), 48'h000080);
        check("post_valid", 48'(pix_valid), 48'h1);

`ifdef TILE_SCROLL_EN
        // Shadowed scroll: sampled only at the frame point on row 192 in blanking
        active = 1'b0;
        tick();
        do_write(2'd0, 16'd1, 48'h05);
        do_write(2'd1, 16'd40, 48'hFF);
        scroll_x = 10'd8;
        show(10'd0, 10'd192, 1'b0);
        show(10'd0, 10'd0, 1'b1);
        check("scroll_x8", 48'(pix_color), 48'h00FF00);
        scroll_x = 10'd0;
        show(10'd0, 10'd0, 1'b1);
        check("scroll_hold", 48'(pix_color), 48'h00FF00);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/tile_renderer.md
Name: tile_renderer

Overview:
- Parametrised character-mode background renderer for the VGA path; successor to the fixed 8x8 test tile generator.
- Pipelined three-table fetch per pixel: name → pattern → colour. Geometry is configurable, plus a border colour for pixels outside the tile field.
- Owns a buffered write port. Table updates are deferred to blanking so no frame tears.
- Sits between vga_counters (pixel column/row, blank) and the top-level RGB mux. The top level delays sync and blank by LATENCY.

Parameters:
- COLS_LOG2, 5: tile columns = 2**COLS_LOG2 (32).
- ROWS, 24: tile rows.
- TILE_LOG2, 3: tile edge = 2**TILE_LOG2 pixels. Legal values are 3 or 4.
- GRP_LOG2, 3: names per colour-table entry = 2**GRP_LOG2. Colour entries = 256 >> GRP_LOG2.
- BORDER, 24'h000000: colour outside the tile field.

Ports:
- clk, in, 1: pixel pipeline clock (50 MHz).
- reset_n, in, 1: asynchronous, active-low reset.
- hcount, in, 10: pixel column (vga hcount[10:1]).
- vcount, in, 10: pixel row.
- active, in, 1: VGA_BLANK_N, aligned with hcount/vcount.
- wr_valid, in, 1: write request.
- wr_ready, out, 1: write buffer empty.
- wr_sel, in, 2: target table. 0 = name, 1 = pattern, 2 = colour, 3 = discard.
- wr_addr, in, 16: table index.
- wr_data, in, 48: name uses [7:0]; pattern uses [2**TILE_LOG2-1:0]; colour uses {fg[47:24], bg[23:0]}.
- pix_color, out, 24: RGB888.
- pix_valid, out, 1: active delayed by LATENCY.

Behaviour:
- Tables are simple-dual-port RAMs. They are not reset; contents are undefined until written.
- Table sizes:
  - Name table: 2**COLS_LOG2 * ROWS entries.
  - Pattern table: 256 * 2**TILE_LOG2 entries.
  - Colour table: 256 >> GRP_LOG2 entries.
- Pipeline, LATENCY = 3 clk. All stages advance every clk; there are no stalls.
  - S1: col = hcount >> TILE_LOG2, row = vcount >> TILE_LOG2. Read name[row*2**COLS_LOG2 + col]. Register in_field = (col < 2**COLS_LOG2) && (row < ROWS), the pixel x bits, and active.
  - S2: read pattern[{name, vcount[TILE_LOG2-1:0]}] and colour[name >> GRP_LOG2]. Forward x, in_field, active.
  - S3: bit = pattern[2**TILE_LOG2-1-x] (MSB is the leftmost pixel). pix_color <= !active_d ? 0 : !in_field_d ? BORDER : (bit ? fg : bg). pix_valid <= active_d.
- Write handshake:
  - A write is accepted on a cycle with wr_valid && wr_ready and is held in a 1-entry pending buffer.
  - wr_ready = !pending.
  - The pending write commits on the first clk with active == 0 at the S1 input, including the acceptance cycle + 1 if blanking. pending clears in the same cycle and wr_ready rises the next cycle.
  - A write with an out-of-range wr_addr, or wr_sel == 3, is accepted and discarded at commit.
  - Display reads during the commit cycle return old data.
- Reset (async assert, sync deassert at the top level): pix_color = 0, pix_valid = 0, pending = 0, wr_ready = 1, all pipeline registers 0. Reset mid-write drops the pending entry.
- wr_valid held during active display leaves wr_ready high until acceptance. After acceptance wr_ready stays low for the rest of the line, through to the first blanking cycle.

Optional Feature:
- Macro TILE_SCROLL_EN.
- With the macro defined:
  - Inputs scroll_x[9:0] and scroll_y[9:0] are added. They are sampled into shadow registers at the first clk where vcount == ROWS*2**TILE_LOG2 and active == 0, i.e. frame-stable.
  - S1 uses (hcount + sx) mod (2**COLS_LOG2 * 2**TILE_LOG2) and (vcount + sy) mod (ROWS * 2**TILE_LOG2). Rows wrap, so in_field depends on the unscrolled coordinates.
  - Shadow registers reset to 0.
- Without the macro: the ports are absent, with no logic or latency change.

Decomposition:
- Package tile_pkg holds:
  - the wr_sel enum (SEL_NAME, SEL_PAT, SEL_COLOR, SEL_NONE);
  - LATENCY = 3;
  - an rgb_t typedef (24-bit);
  - a color_entry_t struct {fg, bg}.
- One sub-module, tile_sdp_ram: parametrised width/depth, registered read, synchronous write. It is instantiated three times.

Test Plan:
- Name[0] = 8'h04, pattern[32..39] = 8'hAA, colour[0] = {fg 0000FF, bg FFFF00}, defaults. Frame scan → pixels (0..7, 0) alternate 0000FF/FFFF00 starting with fg, 3 clk after the hcount input.
- Pixel column 256 (col 32 ≥ 32) with active = 1 → pix_color = BORDER. With active = 0 → 0 and pix_valid = 0.
- Write during active display: wr_ready drops the cycle after acceptance. The table does not change until the first active == 0 cycle. A second wr_valid is stalled until then.
- wr_sel = 3 and name write at addr 768 (out of range) → both accepted; no table changes; display unchanged.
- reset_n pulsed low mid-line with pending = 1 → outputs 0 immediately (asynchronous), wr_ready = 1, pending write lost.
- TILE_LOG2 = 4 with TILE_SCROLL_EN, scroll_x = 16 → pixel 0 shows tile column 1. scroll_x changed mid-frame has no effect until the next frame.
